// File: rtl/hatch_mem_arb_if.sv
// hatch_mem_arb_if: fetch, loader and RAM signals of the hatch memory arbiter.
// slave  = arbiter view (takes requests, drives grants/responses and the RAM side).
// master = requester/RAM view (drives requests and read data).
interface hatch_mem_arb_if #(
   parameter int IW = 6,
   parameter int DW = 48
);
   logic          fetch_req;
   logic [31:0]   fetch_addr;
   logic          fetch_gnt;
   logic          fetch_valid;
   logic [DW-1:0] fetch_data;
   logic          fetch_fault;

   logic          load_req;
   logic          load_we;
   logic [IW-1:0] load_idx;
   logic [DW-1:0] load_wdata;
   logic          load_gnt;
   logic          load_valid;
   logic [DW-1:0] load_rdata;

   logic          mem_en;
   logic          mem_we;
   logic [IW-1:0] mem_idx;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  fetch_req, fetch_addr, load_req, load_we, load_idx, load_wdata, mem_rdata,
      output fetch_gnt, fetch_valid, fetch_data, fetch_fault,
      output load_gnt, load_valid, load_rdata,
      output mem_en, mem_we, mem_idx, mem_wdata
   );

   modport master (
      output fetch_req, fetch_addr, load_req, load_we, load_idx, load_wdata, mem_rdata,
      input  fetch_gnt, fetch_valid, fetch_data, fetch_fault,
      input  load_gnt, load_valid, load_rdata,
      input  mem_en, mem_we, mem_idx, mem_wdata
   );
endinterface

// File: rtl/hatch_mem_arb.sv
// hatch_mem_arb: arbitrates the CPU fetch port (byte addresses) and the loader
// port (word indices) onto one single-port synchronous hatch instruction RAM.
// Fetch has priority, but a waiting load is served after MAX_STREAK fetch grants.
// Optional feature macro: HATCH_FETCH_CHECK_EN -- illegal fetch addresses are not
// sent to the RAM and answer with a fault; the loader may take the freed slot.
module hatch_mem_arb #(
   parameter int DEPTH      = 64,
   parameter int IW         = 6,
   parameter int DW         = 48,
   parameter int MAX_STREAK = 4
) (
   input logic               clk,
   input logic               rst_b,
   hatch_mem_arb_if.slave    bus
);

   localparam int          SW         = $clog2(MAX_STREAK + 1);
   localparam logic [31:0] ADDR_LIMIT = 32'(6 * DEPTH);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

   logic [SW-1:0] streak;
   logic [31:0]   fetch_word;
   logic [IW-1:0] fetch_idx;
   logic          fetch_aligned;
   logic          fetch_in_range;
   logic          fetch_ok;
   logic          fetch_gnt_c;
   logic          load_gnt_c;
   logic          load_fill;
   logic          fetch_pend;
   logic          fault_pend;
   logic          load_pend;
   logic          load_wr_pend;
   logic [DW-1:0] fetch_resp;
   logic [DW-1:0] load_resp;
   logic [DW-1:0] fetch_data_q;
   logic [DW-1:0] load_rdata_q;
   logic          unused_bits;

   // Byte address to word index; legality of the address for the fault check.
   always_comb begin
      fetch_word     = bus.fetch_addr / 32'd6;
      fetch_idx      = fetch_word[IW-1:0];
      fetch_aligned  = (bus.fetch_addr % 32'd6) == 32'd0;
      fetch_in_range = bus.fetch_addr < ADDR_LIMIT;
`ifdef HATCH_FETCH_CHECK_EN
      fetch_ok       = fetch_aligned && fetch_in_range;
`else
      fetch_ok       = 1'b1;
`endif
   end

   assign unused_bits = ^{fetch_word[31:IW], fetch_aligned, fetch_in_range};

   // Grant selection; a faulting fetch leaves the RAM slot free for the loader.
   always_comb begin
      fetch_gnt_c = 1'b0;
      load_gnt_c  = 1'b0;
      load_fill   = 1'b0;
      if (rst_b) begin
         if (bus.fetch_req && (!bus.load_req || streak != STREAK_MAX)) begin
            fetch_gnt_c = 1'b1;
            if (!fetch_ok && bus.load_req) begin
               load_gnt_c = 1'b1;
               load_fill  = 1'b1;
            end
         end else if (bus.load_req) begin
            load_gnt_c = 1'b1;
         end
      end
   end

   // RAM control for the granted requester; all zero when idle.
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_idx   = '0;
      bus.mem_wdata = '0;
      if (load_gnt_c) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.load_we;
         bus.mem_idx   = bus.load_idx;
         bus.mem_wdata = bus.load_we ? bus.load_wdata : '0;
      end else if (fetch_gnt_c && fetch_ok) begin
         bus.mem_en  = 1'b1;
         bus.mem_idx = fetch_idx;
      end
   end

   assign bus.fetch_gnt = fetch_gnt_c;
   assign bus.load_gnt  = load_gnt_c;

   // Starvation counter: consecutive fetch wins while a load waits.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         streak <= '0;
      end else if (!bus.load_req || (load_gnt_c && !load_fill)) begin
         streak <= '0;
      end else if (fetch_gnt_c && !load_fill && streak != STREAK_MAX) begin
         streak <= streak + 1'b1;
      end
   end

   // Per-port response tracking for the cycle after a grant.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         fetch_pend   <= 1'b0;
         fault_pend   <= 1'b0;
         load_pend    <= 1'b0;
         load_wr_pend <= 1'b0;
      end else begin
         fetch_pend   <= fetch_gnt_c;
         fault_pend   <= fetch_gnt_c && !fetch_ok;
         load_pend    <= load_gnt_c;
         load_wr_pend <= load_gnt_c && bus.load_we;
      end
   end

   // RAM read data only becomes valid in the strobe cycle, so the strobe cycle
   // forwards it directly and the holding registers capture it for later cycles.
   always_comb begin
      fetch_resp = fault_pend   ? '0 : bus.mem_rdata;
      load_resp  = load_wr_pend ? '0 : bus.mem_rdata;
   end

   // Hold the last delivered data between strobes.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         fetch_data_q <= '0;
         load_rdata_q <= '0;
      end else begin
         if (fetch_pend) fetch_data_q <= fetch_resp;
         if (load_pend)  load_rdata_q <= load_resp;
      end
   end

   // Reset gating suppresses the response of a grant made just before reset.
   always_comb begin
      bus.fetch_valid = fetch_pend && rst_b;
      bus.fetch_fault = fault_pend && rst_b;
      bus.load_valid  = load_pend && rst_b;
      bus.fetch_data  = '0;
      bus.load_rdata  = '0;
      if (rst_b) begin
         bus.fetch_data = fetch_pend ? fetch_resp : fetch_data_q;
         bus.load_rdata = load_pend  ? load_resp  : load_rdata_q;
      end
   end

endmodule

// File: tb/tb_hatch_mem_arb.sv
// tb_hatch_mem_arb: directed table vectors plus hand sequences for the
// starvation bound and reset during an access. Includes a behavioural RAM.
module tb_hatch_mem_arb;

   localparam int IW = 6;
   localparam int DW = 48;
   localparam int NV = 16;

   localparam logic [47:0] C1 = 48'h123456789ABC;
   localparam logic [47:0] C2 = 48'hFFFF00000001;
   localparam logic [47:0] C3 = 48'hA5A500005A5A;

   typedef struct {
      logic          rst_b;
      logic          freq;
      logic [31:0]   faddr;
      logic          lreq;
      logic          lwe;
      logic [IW-1:0] lidx;
      logic [DW-1:0] lwdata;
      logic          e_fgnt;
      logic          e_lgnt;
      logic          e_men;
      logic          e_mwe;
      logic [IW-1:0] e_midx;
      logic [DW-1:0] e_mwdata;
      logic          e_fvalid;
      logic          e_ffault;
      logic [DW-1:0] e_fdata;
      logic          e_lvalid;
      logic [DW-1:0] e_ldata;
   } vec_t;

   logic clk;
   logic rst_b;
   int   checks;
   int   errors;
   vec_t vt[NV];
   logic [DW-1:0] ram[64];

   hatch_mem_arb_if #(.IW(IW), .DW(DW)) bus ();

   hatch_mem_arb #(
      .DEPTH(64),
      .IW(IW),
      .DW(DW),
      .MAX_STREAK(4)
   ) dut (
      .clk(clk),
      .rst_b(rst_b),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port synchronous RAM model.
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_idx] <= bus.mem_wdata;
         else            bus.mem_rdata    <= ram[bus.mem_idx];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic set_in(input int i, input logic r, input logic fq, input logic [31:0] fa,
                         input logic lq, input logic lw, input logic [IW-1:0] li,
                         input logic [DW-1:0] ld);
      vt[i].rst_b = r;  vt[i].freq = fq; vt[i].faddr = fa;
      vt[i].lreq  = lq; vt[i].lwe  = lw; vt[i].lidx  = li; vt[i].lwdata = ld;
   endtask

   task automatic set_ex(input int i, input logic fg, input logic lg, input logic me,
                         input logic mw, input logic [IW-1:0] mi, input logic [DW-1:0] md,
                         input logic fv, input logic ff, input logic [DW-1:0] fd,
                         input logic lv, input logic [DW-1:0] ldat);
      vt[i].e_fgnt = fg; vt[i].e_lgnt = lg; vt[i].e_men = me; vt[i].e_mwe = mw;
      vt[i].e_midx = mi; vt[i].e_mwdata = md;
      vt[i].e_fvalid = fv; vt[i].e_ffault = ff; vt[i].e_fdata = fd;
      vt[i].e_lvalid = lv; vt[i].e_ldata = ldat;
   endtask

   task automatic drive(input logic r, input logic fq, input logic [31:0] fa, input logic lq,
                        input logic lw, input logic [IW-1:0] li, input logic [DW-1:0] ld);
      @(negedge clk);
      rst_b          = r;
      bus.fetch_req  = fq;
      bus.fetch_addr = fa;
      bus.load_req   = lq;
      bus.load_we    = lw;
      bus.load_idx   = li;
      bus.load_wdata = ld;
      #1;
   endtask

   task automatic check_vec(input string tag, input vec_t v);
      chk({tag, "_fetch_gnt"},   64'(bus.fetch_gnt),   64'(v.e_fgnt));
      chk({tag, "_load_gnt"},    64'(bus.load_gnt),    64'(v.e_lgnt));
      chk({tag, "_mem_en"},      64'(bus.mem_en),      64'(v.e_men));
      chk({tag, "_mem_we"},      64'(bus.mem_we),      64'(v.e_mwe));
      chk({tag, "_mem_idx"},     64'(bus.mem_idx),     64'(v.e_midx));
      chk({tag, "_mem_wdata"},   64'(bus.mem_wdata),   64'(v.e_mwdata));
      chk({tag, "_fetch_valid"}, 64'(bus.fetch_valid), 64'(v.e_fvalid));
      chk({tag, "_fetch_fault"}, 64'(bus.fetch_fault), 64'(v.e_ffault));
      chk({tag, "_fetch_data"},  64'(bus.fetch_data),  64'(v.e_fdata));
      chk({tag, "_load_valid"},  64'(bus.load_valid),  64'(v.e_lvalid));
      chk({tag, "_load_rdata"},  64'(bus.load_rdata),  64'(v.e_ldata));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int load_cycle;
      int fetch_cnt;
      vec_t v;
      checks = 0;
      errors = 0;
      for (int i = 0; i < 64; i++) ram[i] = '0;
      bus.mem_rdata  = '0;
      rst_b          = 1'b0;
      bus.fetch_req  = 1'b0;
      bus.fetch_addr = '0;
      bus.load_req   = 1'b0;
      bus.load_we    = 1'b0;
      bus.load_idx   = '0;
      bus.load_wdata = '0;
      repeat (2) @(posedge clk);

      //          r  fq addr lq lw idx data
      set_in( 0, 0, 0,   0, 0, 0,  0, '0);
      set_ex( 0, 0, 0, 0, 0,  0, '0, 0, 0, '0, 0, '0);
      set_in( 1, 1, 0,   0, 1, 1,  5, C1);
      set_ex( 1, 0, 1, 1, 1,  5, C1, 0, 0, '0, 0, '0);
      set_in( 2, 1, 1,  30, 0, 0,  0, '0);
      set_ex( 2, 1, 0, 1, 0,  5, '0, 0, 0, '0, 1, '0);
      set_in( 3, 1, 0,   0, 0, 0,  0, '0);
      set_ex( 3, 0, 0, 0, 0,  0, '0, 1, 0, C1, 0, '0);
      set_in( 4, 1, 0,   0, 0, 0,  0, '0);
      set_ex( 4, 0, 0, 0, 0,  0, '0, 0, 0, C1, 0, '0);
      set_in( 5, 1, 0,   0, 1, 1, 63, C2);
      set_ex( 5, 0, 1, 1, 1, 63, C2, 0, 0, C1, 0, '0);
      set_in( 6, 1, 1, 378, 0, 0,  0, '0);
      set_ex( 6, 1, 0, 1, 0, 63, '0, 0, 0, C1, 1, '0);
      set_in( 7, 1, 0,   0, 1, 0, 63, '0);
      set_ex( 7, 0, 1, 1, 0, 63, '0, 1, 0, C2, 0, '0);
      set_in( 8, 1, 0,   0, 0, 0,  0, '0);
      set_ex( 8, 0, 0, 0, 0,  0, '0, 0, 0, C2, 1, C2);
      set_in( 9, 1, 0,   0, 1, 1,  0, C3);
      set_ex( 9, 0, 1, 1, 1,  0, C3, 0, 0, C2, 0, C2);
      set_in(10, 1, 1, 384, 0, 0,  0, '0);
      set_in(11, 1, 0,   0, 0, 0,  0, '0);
      set_in(12, 1, 1,  31, 0, 0,  0, '0);
      set_in(13, 1, 0,   0, 0, 0,  0, '0);
      set_in(14, 1, 1,  31, 1, 0,  5, '0);
      set_in(15, 1, 0,   0, 0, 0,  0, '0);
`ifdef HATCH_FETCH_CHECK_EN
      set_ex(10, 1, 0, 0, 0,  0, '0, 0, 0, C2, 1, '0);
      set_ex(11, 0, 0, 0, 0,  0, '0, 1, 1, '0, 0, '0);
      set_ex(12, 1, 0, 0, 0,  0, '0, 0, 0, '0, 0, '0);
      set_ex(13, 0, 0, 0, 0,  0, '0, 1, 1, '0, 0, '0);
      set_ex(14, 1, 1, 1, 0,  5, '0, 0, 0, '0, 0, '0);
      set_ex(15, 0, 0, 0, 0,  0, '0, 1, 1, '0, 1, C1);
`else
      set_ex(10, 1, 0, 1, 0,  0, '0, 0, 0, C2, 1, '0);
      set_ex(11, 0, 0, 0, 0,  0, '0, 1, 0, C3, 0, '0);
      set_ex(12, 1, 0, 1, 0,  5, '0, 0, 0, C3, 0, '0);
      set_ex(13, 0, 0, 0, 0,  0, '0, 1, 0, C1, 0, '0);
      set_ex(14, 1, 0, 1, 0,  5, '0, 0, 0, C1, 0, '0);
      set_ex(15, 0, 0, 0, 0,  0, '0, 1, 0, C1, 0, '0);
`endif

      for (int i = 0; i < NV; i++) begin
         v = vt[i];
         drive(v.rst_b, v.freq, v.faddr, v.lreq, v.lwe, v.lidx, v.lwdata);
         check_vec($sformatf("row%0d", i), v);
      end

      // Reset asserted the cycle after a fetch grant: no strobe, no RAM write.
      drive(1, 1, 30, 0, 0, 0, '0);
      chk("rst_grant_fetch_gnt", 64'(bus.fetch_gnt), 64'd1);
      drive(0, 0, 0, 1, 1, 7, C3);
      v = vt[0];
      check_vec("rst_cyc1", v);
      drive(0, 0, 0, 1, 1, 7, C3);
      check_vec("rst_cyc2", v);
      drive(1, 0, 0, 0, 0, 0, '0);
      check_vec("rst_exit", v);
      drive(1, 1, 42, 0, 0, 0, '0);
      chk("rst_idx7_fetch_gnt", 64'(bus.fetch_gnt), 64'd1);
      drive(1, 0, 0, 0, 0, 0, '0);
      chk("rst_idx7_valid", 64'(bus.fetch_valid), 64'd1);
      chk("rst_idx7_unwritten", 64'(bus.fetch_data), 64'd0);

      // Starvation bound: continuous fetch plus a waiting load read of idx 5.
      load_cycle = 0;
      fetch_cnt  = 0;
      for (int c = 1; c <= 10; c++) begin
         drive(1, 1, 0, 1, 0, 5, '0);
         if (bus.load_gnt) begin
            load_cycle = c;
            break;
         end
         if (bus.fetch_gnt) fetch_cnt++;
      end
      chk("starve_load_cycle", 64'(load_cycle), 64'd5);
      chk("starve_fetch_grants", 64'(fetch_cnt), 64'd4);
      chk("starve_load_fetch_gnt", 64'(bus.fetch_gnt), 64'd0);
      drive(1, 1, 0, 0, 0, 0, '0);
      chk("starve_resume_fetch", 64'(bus.fetch_gnt), 64'd1);
      chk("starve_load_valid", 64'(bus.load_valid), 64'd1);
      chk("starve_load_rdata", 64'(bus.load_rdata), 64'(C1));
      drive(1, 1, 0, 1, 0, 5, '0);
      chk("starve_cleared_fetch", 64'(bus.fetch_gnt), 64'd1);
      chk("starve_cleared_load", 64'(bus.load_gnt), 64'd0);
      chk("starve_fetch_data", 64'(bus.fetch_data), 64'(C3));
      drive(1, 0, 0, 0, 0, 0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hatch_mem_arb.md
# hatch_mem_arb

Arbiter and sequencer for the shared 64-entry × 48-bit hatch instruction memory. Two requesters share one single-port synchronous RAM: the CPU instruction-fetch port, which uses byte addresses, and a loader/debug port, which uses word indices and can read and write. The block sits between `cpu` and the hatch memory inside `top`. It converts fetch byte addresses to word indices (address / 6), checks them, and guarantees the loader cannot be starved by continuous fetch traffic.

## Interface
Parameters:
- `DEPTH`, 64, number of memory words.
- `IW`, 6, index width (log2 DEPTH).
- `DW`, 48, word width.
- `MAX_STREAK`, 4, maximum consecutive fetch grants while a load request waits.

Ports:
- `clk` in 1: the single clock.
- `rst_b` in 1: reset, synchronous, active-low.
- `fetch_req` in 1: fetch request, held until granted.
- `fetch_addr` in 32: fetch byte address, sampled on grant.
- `fetch_gnt` out 1: single-cycle grant.
- `fetch_valid` out 1: response strobe.
- `fetch_data` out DW: fetched instruction.
- `fetch_fault` out 1: response is a fault.
- `load_req` in 1: loader request.
- `load_we` in 1: 1 = write.
- `load_idx` in IW: loader word index.
- `load_wdata` in DW: loader write data.
- `load_gnt` out 1: loader grant.
- `load_valid` out 1: loader response strobe.
- `load_rdata` out DW: loader read data.
- `mem_en` out 1: RAM enable.
- `mem_we` out 1: RAM write enable.
- `mem_idx` out IW: RAM index.
- `mem_wdata` out DW: RAM write data.
- `mem_rdata` in DW: RAM read data, valid one cycle after `mem_en` with `mem_we` = 0.

## Operation
Arbitration happens each cycle while `rst_b` = 1.
- **Only one request pending:** that requester is granted.
- **Both requests pending:** fetch wins unless `streak == MAX_STREAK`, in which case load wins.
- **Streak counter (0..MAX_STREAK):**
  - Increments on a fetch grant while `load_req` = 1.
  - Clears on a load grant, or in any cycle where `load_req` = 0.
  - Saturates at MAX_STREAK.

Grant cycle:
- The matching `*_gnt` is driven high combinationally.
- The `mem_*` outputs are driven combinationally for that requester.
- Requester inputs are sampled in the grant cycle and may change in the next cycle.

Fetch index:
- `idx = fetch_addr / 6`, where a legal address is one with `fetch_addr < 6*DEPTH` and `fetch_addr % 6 == 0`.
- Index arithmetic is done at 32 bits and truncated to IW bits.

Responses are registered and arrive exactly one cycle after the grant:
- **Fetch read:** `fetch_valid` = 1, `fetch_data` = `mem_rdata`, `fetch_fault` = 0.
- **Load read:** `load_valid` = 1, `load_rdata` = `mem_rdata`.
- **Load write:**
  - The RAM is written in the grant cycle.
  - `load_valid` pulses as an acknowledgement, with `load_rdata` = 0.
- **Data registers:** `fetch_data` and `load_rdata` hold their last value between strobes.

Throughput: back-to-back grants are allowed every cycle, so each port has at most one grant per cycle and full throughput of one access per cycle overall.

Idle cycles: when no grant is issued, `mem_en` = 0, `mem_we` = 0, `mem_idx` = 0 and `mem_wdata` = 0.

## Timing
Reset values (whenever `rst_b` = 0 at a clock edge):
- Registered outputs `fetch_valid`, `fetch_fault`, `load_valid`, `fetch_data` and `load_rdata` reset to 0.
- The streak counter resets to 0.

Behaviour while `rst_b` = 0:
- `fetch_gnt`, `load_gnt`, `mem_en` and `mem_we` are forced to 0 (no grants and no RAM writes while in reset).
- A grant issued in the cycle immediately before reset assertion produces no response strobe.

Latency: grant to strobe is 1 cycle for every access type, including faults.

Handshake: a request must be held high until its grant is seen. Dropping a request before its grant is legal and has no side effects.

Simultaneous events: a write to index `i` in cycle N followed by a fetch of index `i` in cycle N+1 returns the new data.

## Configuration
- **`HATCH_FETCH_CHECK_EN` defined:**
  - An illegal fetch address still produces a fetch grant, but `mem_en` = 0 in that cycle (the RAM is not accessed).
  - The loader may use that RAM slot in the same cycle if `load_req` = 1. This does not count as a load-starvation grant, and the streak counter is unchanged.
  - The response, one cycle later, is `fetch_valid` = 1, `fetch_fault` = 1, `fetch_data` = 0.
- **`HATCH_FETCH_CHECK_EN` not defined:**
  - No address checking is done; `fetch_fault` is tied to 0.
  - The index is `(fetch_addr / 6)` truncated to IW bits, so out-of-range addresses wrap around.

## Test plan
- **Basic fetch:** write 0x123456789ABC to idx 5 via the loader, then fetch addr 30 → `fetch_valid` one cycle after grant, `fetch_data` = 0x123456789ABC, `fetch_fault` = 0.
- **Starvation bound:** hold `fetch_req` high continuously and raise `load_req` → load is granted on the 5th contention cycle (after exactly 4 fetch grants), then fetch resumes.
- **Fault check:** with `HATCH_FETCH_CHECK_EN`, fetch addr 31 and addr 384 → each gives `fetch_fault` = 1, `fetch_data` = 0, `mem_en` = 0. Without the macro, addr 384 returns the word at idx 0.
- **Write-then-read:** load write idx 63 = 0xFFFF00000001, then fetch addr 378 in the next cycle → returns 0xFFFF00000001.
- **Reset mid-access:** grant a fetch in cycle N, drive `rst_b` low in cycle N+1 → no `fetch_valid`; all outputs are 0 and no `mem_we` is asserted during reset.
